// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: load-use bubbles, taken-branch flushes and
// whole-pipe freezes for a busy data memory, with saturating event counters.
module hazard_stall_controller #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_write_reg,
   input  logic             branch_taken,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_maintain,
   output logic             idex_bubble,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      FLUSH    = 2'd2,
      MEM_WAIT = 2'd3
   } state_t;

   state_t state, nextState;
   logic   luh;
   logic   luhEn;
   logic   branchEn;

   assign luh = ex_mem_read && (ex_write_reg != 5'd0) &&
                ((ex_write_reg == id_rs1) || (id_uses_rs2 && (ex_write_reg == id_rs2)));

   // MEM_WAIT behaves as RUN once memory is ready; LU_STALL and FLUSH mask the
   // hazard (one bubble per load-use, wrong-path ID), FLUSH also masks branches.
   assign luhEn    = (state == RUN) || (state == MEM_WAIT);
   assign branchEn = (state != FLUSH);
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= RUN;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = RUN;
      if (mem_busy) begin
         nextState = MEM_WAIT;
      end else if (branchEn && branch_taken) begin
         nextState = FLUSH;
      end else if (luhEn && luh) begin
         nextState = LU_STALL;
      end
   end

   always_comb begin
      pc_write      = 1'b1;
      ifid_write    = 1'b1;
      idex_maintain = 1'b0;
      idex_bubble   = 1'b0;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      exmem_flush   = 1'b0;
      if (!reset_n) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end else if (mem_busy) begin
         pc_write      = 1'b0;
         ifid_write    = 1'b0;
         idex_maintain = 1'b1;
      end else if (branchEn && branch_taken) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else if (luhEn && luh) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   // Counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (!pc_write && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
         end
         if (exmem_flush && (flush_count != {CNT_W{1'b1}})) begin
            flush_count <= flush_count + 1'b1;
         end
      end
   end

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter CNT_W: default 16; width of the stall and flush event counters.
REQ-003 clk  input  1  rising-edge clock shared with all pipeline registers.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 id_rs1  input  5  source register 1 of the instruction in ID.
REQ-006 id_rs2  input  5  source register 2 of the instruction in ID.
REQ-007 id_uses_rs2  input  1  the instruction in ID reads rs2 (R-type, store, branch).
REQ-008 ex_mem_read  input  1  MemRead held in the ID/EX register output.
REQ-009 ex_write_reg  input  5  WriteReg held in the ID/EX register output.
REQ-010 branch_taken  input  1  branch resolved taken at the EX/MEM register output.
REQ-011 mem_busy  input  1  data memory needs another cycle; the whole pipe must freeze.
REQ-012 pc_write  output  1  PC update enable.
REQ-013 ifid_write  output  1  IF/ID load enable.
REQ-014 idex_maintain  output  1  drives the ID/EX register hold input; 1 means the register keeps its contents.
REQ-015 idex_bubble  output  1  load zeros into the ID/EX control fields (NOP).
REQ-016 ifid_flush, idex_flush, exmem_flush  output  1 each  clear the named pipeline register.
REQ-017 stall_count  output  CNT_W  stall cycles counted since reset.
REQ-018 flush_count  output  CNT_W  taken-branch flush events counted since reset.

Function
REQ-019 States: RUN, LU_STALL, FLUSH, MEM_WAIT; all outputs SHALL be combinational from state and current inputs, and all state and counters SHALL be registered.
REQ-020 Load-use hazard (luh) SHALL be: ex_mem_read & (ex_write_reg != 0) & (ex_write_reg == id_rs1 | (id_uses_rs2 & ex_write_reg == id_rs2)).
REQ-021 Default outputs (no event): pc_write=1, ifid_write=1, all other 1-bit outputs 0.
REQ-022 Priority in RUN SHALL be mem_busy > branch_taken > luh.
REQ-023 RUN & mem_busy: pc_write=0, ifid_write=0, idex_maintain=1, no flush; next state MEM_WAIT.
REQ-024 RUN & branch_taken & !mem_busy: ifid_flush=1, idex_flush=1, exmem_flush=1, pc_write=1; next state FLUSH.
REQ-025 RUN & luh & !branch_taken & !mem_busy: pc_write=0, ifid_write=0, idex_bubble=1; next state LU_STALL; exactly one bubble per load-use.
REQ-026 LU_STALL: default outputs with luh masked; next state RUN, or MEM_WAIT if mem_busy, or FLUSH if branch_taken, using the REQ-022 priority and outputs.
REQ-027 FLUSH: default outputs with luh masked (the instruction in ID is wrong-path); branch_taken is ignored for this one cycle; next state RUN, or MEM_WAIT if mem_busy.
REQ-028 MEM_WAIT & mem_busy: freeze outputs as REQ-023; stay in MEM_WAIT.
REQ-029 MEM_WAIT & !mem_busy: outputs and next state SHALL equal those of RUN for the same inputs in that same cycle, so a branch_taken or luh held across the freeze is serviced immediately.
REQ-030 stall_count SHALL increment by 1 on each cycle with pc_write=0 while reset_n=1, and saturate at all-ones.
REQ-031 flush_count SHALL increment by 1 on each cycle with exmem_flush=1, and saturate at all-ones.
REQ-032 idex_maintain and idex_bubble SHALL never both be 1 in the same cycle.

Reset
REQ-033 On a clk edge with reset_n=0, state SHALL become RUN and both counters SHALL become 0, including mid-stall or mid-flush.
REQ-034 While reset_n=0: pc_write=0, ifid_write=0, idex_maintain=0, idex_bubble=1, all flush outputs 0.
REQ-035 On the first cycle after reset_n rises, outputs SHALL be the RUN outputs for the current inputs.

Verification
REQ-036 Load-use test: ex_mem_read=1, ex_write_reg=5, id_rs1=5 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1; next cycle default outputs with inputs unchanged; stall_count=1.
REQ-037 x0 and rs2 masking tests: ex_write_reg=0 with id_rs1=0 -> no stall; ex_write_reg=7, id_rs2=7, id_uses_rs2=0 -> no stall.
REQ-038 Branch test: branch_taken=1 for 2 cycles -> three flushes in cycle 1 only, default outputs in cycle 2, flush_count=1.
REQ-039 Memory freeze test: mem_busy=1 for 3 cycles with branch_taken=1 held -> idex_maintain=1 and pc_write=0 for 3 cycles; flushes in the 4th cycle; stall_count=3; flush_count=1.
REQ-040 Priority test: luh=1 and branch_taken=1 together -> flush outputs only, idex_bubble=0.
REQ-041 Reset test: assert reset_n=0 in LU_STALL with stall_count=9 -> next edge gives state RUN and stall_count=0; REQ-034 outputs hold while reset_n=0.
